strided_split: RTL and testbench

STRIDED_SPLIT -- requirements
Module: strided_split

---
 rtl/strided_split_pkg.sv | 7 +
 rtl/strided_index_gen.sv | 66 ++++++
 rtl/strided_split.sv | 79 +++++++
 tb/tb_strided_split.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/strided_split_pkg.sv
// Shared lane constants for the strided splitter.
//   NUM_LANES : number of parallel output lanes
//   LANE_W    : width of the lane index
package strided_split_pkg;
  localparam int NUM_LANES = 16;
  localparam int LANE_W    = 4;
endpackage

// File: rtl/strided_index_gen.sv
// Delay / stride / lane-index sequencer.
// Ports:
//   clk, rst (async active-low)
//   run      : start pulse, reloads the sequencer
//   running  : run-window qualifier
//   stride   : captures per lane minus one
//   delay0   : running cycles skipped before the first capture
//   cap_o    : capture strobe for this cycle
//   lane_o   : lane written when cap_o is high
module strided_index_gen
  import strided_split_pkg::*;
#(
  parameter int DELAY_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               running,
  input  logic [DELAY_W-1:0] stride,
  input  logic [DELAY_W-1:0] delay0,
  output logic               cap_o,
  output logic [LANE_W-1:0]  lane_o
);
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [DELAY_W-1:0] str_q, str_d;
  logic [LANE_W-1:0]  lane_q, lane_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_q  <= '0;
      str_q  <= '0;
      lane_q <= '0;
    end else begin
      dly_q  <= dly_d;
      str_q  <= str_d;
      lane_q <= lane_d;
    end
  end

  // run has priority over running: a start cycle never captures.
  always_comb begin
    dly_d  = dly_q;
    str_d  = str_q;
    lane_d = lane_q;
    cap_o  = 1'b0;
    if (run) begin
      dly_d  = delay0;
      str_d  = '0;
      lane_d = '0;
    end else if (running) begin
      if (dly_q != '0) begin
        dly_d = dly_q - DELAY_W'(1);
      end else begin
        cap_o = 1'b1;
        if (str_q == stride) begin
          str_d  = '0;
          lane_d = lane_q + LANE_W'(1); // wraps 15 -> 0 naturally
        end else begin
          str_d = str_q + DELAY_W'(1);
        end
      end
    end
  end

  assign lane_o = lane_q;
endmodule

// File: rtl/strided_split.sv
// Serial-to-parallel strided splitter: each of 16 lanes keeps the last of
// stride+1 consecutive samples of in0, after delay0 skipped running cycles.
// Ports:
//   clk, rst (async active-low)
//   run, running   : start pulse and run-window qualifier
//   in0            : serial data in
//   stride, delay0 : sequencing configuration
//   out0..out15    : lane registers
module strided_split
  import strided_split_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               running,
  input  logic [DATA_W-1:0]  in0,
  input  logic [DELAY_W-1:0] stride,
  input  logic [DELAY_W-1:0] delay0,
  output logic [DATA_W-1:0]  out0,
  output logic [DATA_W-1:0]  out1,
  output logic [DATA_W-1:0]  out2,
  output logic [DATA_W-1:0]  out3,
  output logic [DATA_W-1:0]  out4,
  output logic [DATA_W-1:0]  out5,
  output logic [DATA_W-1:0]  out6,
  output logic [DATA_W-1:0]  out7,
  output logic [DATA_W-1:0]  out8,
  output logic [DATA_W-1:0]  out9,
  output logic [DATA_W-1:0]  out10,
  output logic [DATA_W-1:0]  out11,
  output logic [DATA_W-1:0]  out12,
  output logic [DATA_W-1:0]  out13,
  output logic [DATA_W-1:0]  out14,
  output logic [DATA_W-1:0]  out15
);
  logic                               cap;
  logic [LANE_W-1:0]                  lane;
  logic [NUM_LANES-1:0][DATA_W-1:0]   lanes_q;

  strided_index_gen #(.DELAY_W(DELAY_W)) u_idx (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .running (running),
    .stride  (stride),
    .delay0  (delay0),
    .cap_o   (cap),
    .lane_o  (lane)
  );

  // Only the addressed lane loads; all others hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lanes_q <= '0;
    end else if (cap) begin
      lanes_q[lane] <= in0;
    end
  end

  assign out0  = lanes_q[0];
  assign out1  = lanes_q[1];
  assign out2  = lanes_q[2];
  assign out3  = lanes_q[3];
  assign out4  = lanes_q[4];
  assign out5  = lanes_q[5];
  assign out6  = lanes_q[6];
  assign out7  = lanes_q[7];
  assign out8  = lanes_q[8];
  assign out9  = lanes_q[9];
  assign out10 = lanes_q[10];
  assign out11 = lanes_q[11];
  assign out12 = lanes_q[12];
  assign out13 = lanes_q[13];
  assign out14 = lanes_q[14];
  assign out15 = lanes_q[15];
endmodule

// File: tb/tb_strided_split.sv
module tb_strided_split;
  localparam int DW = 8;
  localparam int LW = 2;

  typedef struct {
    string                 name;
    logic [15:0]           mask;
    logic [15:0][DW-1:0]   val;
  } exp_t;

  logic clk = 0, rst = 0, run = 0, running = 0;
  logic [DW-1:0] in0 = '0;
  logic [LW-1:0] stride = '0, delay0 = '0;
  logic [DW-1:0] o [16];
  logic [15:0][DW-1:0] outs;

  exp_t sb[$];
  logic chk = 0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  strided_split #(.DATA_W(DW), .DELAY_W(LW)) dut (
    .clk(clk), .rst(rst), .run(run), .running(running), .in0(in0),
    .stride(stride), .delay0(delay0),
    .out0(o[0]), .out1(o[1]), .out2(o[2]), .out3(o[3]),
    .out4(o[4]), .out5(o[5]), .out6(o[6]), .out7(o[7]),
    .out8(o[8]), .out9(o[9]), .out10(o[10]), .out11(o[11]),
    .out12(o[12]), .out13(o[13]), .out14(o[14]), .out15(o[15])
  );

  always_comb for (int k = 0; k < 16; k++) outs[k] = o[k];

  // Monitor: pops the expected snapshot whenever a check is presented.
  always @(negedge clk) begin
    if (chk) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty: no expected entry queued");
      end else begin
        exp_t e;
        e = sb.pop_front();
        for (int k = 0; k < 16; k++) begin
          if (e.mask[k]) begin
            total++;
            if (outs[k] !== e.val[k]) begin
              bad++;
              $display("FAIL %s out%0d: got %0d expected %0d", e.name, k, outs[k], e.val[k]);
            end
          end
        end
      end
    end
  end

  // Inputs applied just after a rising edge; they are sampled by the next one.
  task automatic drive(input logic r, input logic rn, input logic [DW-1:0] d);
    run = r; running = rn; in0 = d;
    @(posedge clk); #1;
  endtask

  task automatic check(input string nm, input logic [15:0] m, input logic [15:0][DW-1:0] v);
    exp_t e;
    e.name = nm; e.mask = m; e.val = v;
    sb.push_back(e);
    chk = 1;
    @(negedge clk); #1;
    chk = 0;
  endtask

  logic [15:0][DW-1:0] ev;

  initial begin
    // reset state
    #2;
    ev = '0;
    check("reset", 16'hFFFF, ev);
    @(posedge clk); #1 rst = 1;

    // S1: stride 0, delay 0
    stride = 0; delay0 = 0;
    drive(1, 1, 8'd200);
    for (int k = 0; k < 16; k++) drive(0, 1, DW'(k));
    for (int k = 0; k < 16; k++) ev[k] = DW'(k);
    check("s1", 16'hFFFF, ev);

    // S2: stride 3, out0 tracks samples 0..3, then out_k = 4k+3
    stride = 3;
    drive(1, 1, 8'd201);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, DW'(k + 100));
      ev[0] = DW'(k + 100);
      check("s2_out0", 16'h0001, ev);
    end
    for (int k = 4; k < 64; k++) drive(0, 1, DW'(k));
    for (int k = 0; k < 16; k++) ev[k] = DW'(4 * k + 3);
    ev[0] = 8'd103;
    check("s2", 16'hFFFF, ev);

    // S3: delay0 3 discards the first three samples
    stride = 0; delay0 = 3;
    drive(1, 1, 8'd202);
    for (int k = 0; k < 19; k++) drive(0, 1, DW'(k));
    for (int k = 0; k < 16; k++) ev[k] = DW'(k + 3);
    check("s3", 16'hFFFF, ev);

    // S4: 17 samples wrap into out0
    delay0 = 0;
    drive(1, 1, 8'd203);
    for (int k = 0; k < 17; k++) drive(0, 1, DW'(k));
    for (int k = 0; k < 16; k++) ev[k] = DW'(k);
    ev[0] = 8'd16;
    check("s4", 16'hFFFF, ev);

    // S5: gap in running, then run+running together
    drive(1, 1, 8'd204);
    for (int k = 0; k < 5; k++) drive(0, 1, DW'(40 + k));
    for (int k = 0; k < 5; k++) ev[k] = DW'(40 + k);
    check("s5_pre", 16'hFFFF, ev);
    for (int k = 0; k < 5; k++) drive(0, 0, 8'd99);
    check("s5_gap", 16'hFFFF, ev);
    drive(0, 1, 8'd45);
    ev[5] = 8'd45;
    check("s5_resume", 16'hFFFF, ev);
    drive(1, 1, 8'd77);
    check("s5_runcap", 16'hFFFF, ev);
    drive(0, 1, 8'd50);
    ev[0] = 8'd50;
    check("s5_restart", 16'hFFFF, ev);

    // S6: asynchronous reset mid-sequence
    drive(0, 1, 8'd51);
    drive(0, 1, 8'd52);
    run = 0; running = 1; in0 = 8'd88;
    #1 rst = 0;
    ev = '0;
    check("s6_async", 16'hFFFF, ev);
    running = 0;
    @(posedge clk); #1 rst = 1;
    drive(0, 1, 8'd9);
    ev[0] = 8'd9;
    check("s6_nodelay", 16'hFFFF, ev);
    drive(1, 1, 8'd205);
    drive(0, 1, 8'd20);
    drive(0, 1, 8'd21);
    ev[0] = 8'd20; ev[1] = 8'd21;
    check("s6_rerun", 16'hFFFF, ev);

    drive(0, 0, 8'd0);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
